fpu_add_norm_stage: RTL and testbench
=====================================

// Module: fpu_add_norm_stage
// PURPOSE
//  Post-addition normalisation stage of the FP32 adder. It takes the raw signed-magnitude sum
//  (carry + hidden + fraction + GRS), finds the leading one with four LOPD_8bit instances,
//  then shifts the mantissa and adjusts the exponent. The result feeds the rounding stage.
//  It is a 2-stage valid/ready pipeline: S1 does leading-one detection, S2 does shift/adjust.
// PARAMETERS
//  MANT_W  28  input sum width: [27]=carry, [26]=hidden, [25:3]=fraction, [2:0]=G,R,S
//  EXP_W   8   exponent width; biased, max value 2**EXP_W-1 = 255
// PORTS
//  i_clk      in   1        clock; all state updates on rising edge
//  i_rst      in   1        synchronous reset, active-high
//  i_valid    in   1        input sum valid
//  o_ready    out  1        stage can accept input this cycle
//  i_sum_mant in   MANT_W   unnormalised sum magnitude; bit0 already holds sticky
//  i_exp      in   EXP_W    exponent of the larger operand
//  i_sign     in   1        result sign
//  o_valid    out  1        normalised result valid
//  i_ready    in   1        rounding stage accepts the result
//  o_mant     out  MANT_W-1 normalised: [26]=hidden, [2:0]=G,R,S
//  o_exp      out  EXP_W    adjusted exponent
//  o_sign     out  1        result sign
//  o_zero     out  1        exact zero result
//  o_ovf      out  1        exponent overflow (result is inf)
//  o_denorm   out  1        result is subnormal (o_exp=0)
// BEHAVIOUR
//  - Reset: s1_valid=s2_valid=0, o_valid=0, all data/flag outputs 0. Reset in mid-operation
//    drops any in-flight items and does not output them.
//  - Handshake: a transfer happens when valid&&ready. S1 loads when ~s1_valid|s2_load.
//    s2_load = s1_valid&(~s2_valid|i_ready). o_ready = ~s1_valid|s2_load (combinational).
//    Outputs stay stable while o_valid&~i_ready. No item is lost or duplicated.
//  - Latency: 2 cycles from input accept to o_valid. Throughput is 1 per cycle when i_ready=1.
//  - S1: the detector input is {i_sum_mant,4'b0} (32 bits). It is split into 4 bytes, and each
//    byte goes to one LOPD_8bit. lz = 8*(index of the first nonzero byte from the MSB) + pos_one
//    of that byte, range 0..31. zero = all byte zero flags set. S1 registers mant, exp, sign,
//    lz, zero.
//  - S2, evaluated in priority order:
//    zero:        o_mant=0, o_exp=0, o_sign=0, o_zero=1.
//    lz==0:       o_mant={m[27:2], m[1]|m[0]} (sticky kept). exp+1. If exp+1==255:
//                 o_exp=255, o_mant=0, o_ovf=1.
//    lz>=1, exp>lz-1: o_mant = m[26:0] << (lz-1), zeros fill in. o_exp = exp-(lz-1).
//    lz>=1, exp<=lz-1: subnormal. Shift left by (exp==0 ? 0 : exp-1). o_exp=0, o_denorm=1.
//  - The flags are one-hot or all 0, and are valid only when o_valid=1.
//  - i_exp==255 at the input is not allowed (inf/NaN bypass this stage upstream).
// TESTING
//  T1 carry: mant=28'h8000000, exp=127 -> 2 cycles later o_mant=27'h4000000, o_exp=128, flags 0
//  T2 sticky: mant=28'h8000003, exp=127 -> o_mant=27'h4000001, o_exp=128
//  T3 no shift: mant=28'h4000001, exp=100 -> o_mant=27'h4000001, o_exp=100
//  T4 cancel: mant=28'h0000010, exp=100 -> lz=23, o_mant=27'h4000000, o_exp=78
//  T5 subnormal: mant=28'h0000010, exp=10 -> o_mant=27'h0002000, o_exp=0, o_denorm=1
//  T6 zero/ovf: mant=0, exp=50 -> o_zero=1, o_exp=0, o_sign=0;
//               mant=28'h8000000, exp=254 -> o_exp=255, o_mant=0, o_ovf=1
//  T7 backpressure: push 4 back-to-back items with i_ready=0 for 3 cycles.
//               -> o_ready drops after 2 items accepted; the output order equals the input
//                  order with no loss/dup. Apply i_rst mid-stream -> o_valid=0 the next cycle.

Source files
------------

// File: rtl/fpu_add_norm_stage_if.sv
// Handshake and payload bundle for the FP32 adder normalisation stage.
//   master: upstream/downstream environment (drives i_*, observes o_*)
//   slave : the normalisation stage (observes i_*, drives o_*)
//   i_valid/o_ready     : input sum handshake
//   i_sum_mant/i_exp/i_sign : raw sum magnitude, larger-operand exponent, sign
//   o_valid/i_ready     : result handshake toward the rounding stage
//   o_mant/o_exp/o_sign : normalised mantissa (hidden + fraction + GRS), exponent, sign
//   o_zero/o_ovf/o_denorm : one-hot result class flags (all 0 for a normal result)
interface fpu_add_norm_stage_if #(
    parameter int unsigned MANT_W = 28,
    parameter int unsigned EXP_W  = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [MANT_W-1:0] i_sum_mant;
    logic [EXP_W-1:0]  i_exp;
    logic              i_sign;

    logic              o_valid;
    logic              i_ready;
    logic [MANT_W-2:0] o_mant;
    logic [EXP_W-1:0]  o_exp;
    logic              o_sign;
    logic              o_zero;
    logic              o_ovf;
    logic              o_denorm;

    modport master (
        output i_valid, i_sum_mant, i_exp, i_sign, i_ready,
        input  o_ready, o_valid, o_mant, o_exp, o_sign, o_zero, o_ovf, o_denorm
    );

    modport slave (
        input  i_valid, i_sum_mant, i_exp, i_sign, i_ready,
        output o_ready, o_valid, o_mant, o_exp, o_sign, o_zero, o_ovf, o_denorm
    );
endinterface

// File: rtl/fpu_add_norm_stage.sv
// Post-addition normalisation stage of the FP32 adder, 2-stage valid/ready pipeline.
//   S1: leading-one detection over {sum, 4'b0} using four 8-bit detectors.
//   S2: mantissa shift and exponent adjust (carry, normal, subnormal, zero, overflow).
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous reset, active-high; drops in-flight items
//   bus   : fpu_add_norm_stage_if.slave (input sum handshake + normalised result handshake)

// Leading-one position within one byte, counted from the MSB; zero flags an all-zero byte.
module lopd_8bit (
    input  logic [7:0] data,
    output logic [2:0] pos_one,
    output logic       zero
);
    // Later (higher) bits overwrite earlier ones, so the MSB-most one wins.
    always_comb begin
        pos_one = '0;
        zero    = (data == 8'd0);
        for (int i = 0; i < 8; i++) begin
            if (data[i]) pos_one = 3'(7 - i);
        end
    end
endmodule

module fpu_add_norm_stage #(
    parameter int unsigned MANT_W = 28,
    parameter int unsigned EXP_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fpu_add_norm_stage_if.slave  bus
);
    localparam int unsigned DET_W  = MANT_W + 4;
    localparam int unsigned LZ_W   = 5;
    localparam int unsigned OUT_W  = MANT_W - 1;
    localparam int unsigned NBYTES = DET_W / 8;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    // ---------------- S1: leading-one detection ----------------
    logic [DET_W-1:0] det;
    logic [2:0]       byte_pos [NBYTES];
    logic [NBYTES-1:0] byte_zero;
    logic [LZ_W-1:0]  lz_c;
    logic             det_zero_c;

    assign det = {bus.i_sum_mant, 4'b0};

    for (genvar g = 0; g < NBYTES; g++) begin : g_lopd
        lopd_8bit u_lopd (
            .data    (det[8*g+7 -: 8]),
            .pos_one (byte_pos[g]),
            .zero    (byte_zero[g])
        );
    end

    // lz = 8*byte_index + pos_one, i.e. {byte_index, pos_one} with byte 3 as index 0.
    always_comb begin
        lz_c = '0;
        if (!byte_zero[3])      lz_c = {2'd0, byte_pos[3]};
        else if (!byte_zero[2]) lz_c = {2'd1, byte_pos[2]};
        else if (!byte_zero[1]) lz_c = {2'd2, byte_pos[1]};
        else                    lz_c = {2'd3, byte_pos[0]};
    end

    assign det_zero_c = &byte_zero;

    // ---------------- pipeline registers ----------------
    logic              s1_valid, s1_valid_nx;
    logic [MANT_W-1:0] s1_mant;
    logic [EXP_W-1:0]  s1_exp;
    logic              s1_sign;
    logic [LZ_W-1:0]   s1_lz;
    logic              s1_zero;

    logic              out_valid, out_valid_nx;
    logic [OUT_W-1:0]  out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_zero;
    logic              out_ovf;
    logic              out_denorm;

    // ---------------- handshake ----------------
    logic s1_load;
    logic s2_load;

    assign s2_load     = s1_valid & (~out_valid | bus.i_ready);
    assign bus.o_ready = ~s1_valid | s2_load;
    assign s1_load     = bus.i_valid & bus.o_ready;

    // Valid next-state: load wins over drain so back-to-back items keep flowing.
    always_comb begin
        s1_valid_nx  = s1_valid;
        out_valid_nx = out_valid;
        if (s1_load)      s1_valid_nx = 1'b1;
        else if (s2_load) s1_valid_nx = 1'b0;
        if (s2_load)          out_valid_nx = 1'b1;
        else if (bus.i_ready) out_valid_nx = 1'b0;
    end

    // ---------------- S2: shift / exponent adjust ----------------
    logic [LZ_W-1:0]  sh;
    logic [EXP_W:0]   exp_inc;
    logic [LZ_W-1:0]  sub_sh;
    logic [OUT_W-1:0] nx_mant;
    logic [EXP_W-1:0] nx_exp;
    logic             nx_sign;
    logic             nx_zero;
    logic             nx_ovf;
    logic             nx_denorm;

    // Hidden bit sits at m[26]; a leading one at m[26-k] needs a left shift of k = lz-1.
    assign sh      = s1_lz - LZ_W'(1);
    assign exp_inc = {1'b0, s1_exp} + (EXP_W+1)'(1);

    always_comb begin
        nx_mant   = '0;
        nx_exp    = '0;
        nx_sign   = 1'b0;
        nx_zero   = 1'b0;
        nx_ovf    = 1'b0;
        nx_denorm = 1'b0;
        sub_sh    = '0;
        if (s1_zero) begin
            nx_zero = 1'b1;
        end else if (s1_lz == '0) begin
            // Carry out: shift right by one, folding the dropped bit into sticky.
            nx_sign = s1_sign;
            if (exp_inc == (EXP_W+1)'(EXP_MAX)) begin
                nx_exp = EXP_MAX;
                nx_ovf = 1'b1;
            end else begin
                nx_mant = {s1_mant[MANT_W-1:2], s1_mant[1] | s1_mant[0]};
                nx_exp  = exp_inc[EXP_W-1:0];
            end
        end else if (s1_exp > EXP_W'(sh)) begin
            nx_sign = s1_sign;
            nx_mant = s1_mant[OUT_W-1:0] << sh;
            nx_exp  = s1_exp - EXP_W'(sh);
        end else begin
            // Exponent runs out before the hidden bit: shift only down to the subnormal range.
            nx_sign   = s1_sign;
            sub_sh    = (s1_exp == '0) ? '0 : LZ_W'(s1_exp - EXP_W'(1));
            nx_mant   = s1_mant[OUT_W-1:0] << sub_sh;
            nx_denorm = 1'b1;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_mant    <= '0;
            s1_exp     <= '0;
            s1_sign    <= 1'b0;
            s1_lz      <= '0;
            s1_zero    <= 1'b0;
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_sign   <= 1'b0;
            out_zero   <= 1'b0;
            out_ovf    <= 1'b0;
            out_denorm <= 1'b0;
        end else begin
            s1_valid  <= s1_valid_nx;
            out_valid <= out_valid_nx;
            if (s1_load) begin
                s1_mant <= bus.i_sum_mant;
                s1_exp  <= bus.i_exp;
                s1_sign <= bus.i_sign;
                s1_lz   <= lz_c;
                s1_zero <= det_zero_c;
            end
            if (s2_load) begin
                out_mant   <= nx_mant;
                out_exp    <= nx_exp;
                out_sign   <= nx_sign;
                out_zero   <= nx_zero;
                out_ovf    <= nx_ovf;
                out_denorm <= nx_denorm;
            end
        end
    end

    assign bus.o_valid  = out_valid;
    assign bus.o_mant   = out_mant;
    assign bus.o_exp    = out_exp;
    assign bus.o_sign   = out_sign;
    assign bus.o_zero   = out_zero;
    assign bus.o_ovf    = out_ovf;
    assign bus.o_denorm = out_denorm;
endmodule

// File: tb/tb_fpu_add_norm_stage.sv
// Self-checking bench for fpu_add_norm_stage: directed cases with literal expected
// results, backpressure and mid-stream reset, then randomised traffic against a model.
module tb_fpu_add_norm_stage;
    typedef struct packed {
        logic [26:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        zero;
        logic        ovf;
        logic        denorm;
    } res_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    res_t sb [$];
    res_t pend;

    fpu_add_norm_stage_if #(.MANT_W(28), .EXP_W(8)) bus ();

    fpu_add_norm_stage #(.MANT_W(28), .EXP_W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t mk(logic [26:0] m, logic [7:0] e, logic s,
                                logic z, logic o, logic d);
        res_t r;
        r.mant = m; r.exp = e; r.sign = s; r.zero = z; r.ovf = o; r.denorm = d;
        return r;
    endfunction

    // Reference normalisation working directly from the highest set bit of the sum.
    function automatic res_t model(logic [27:0] m, logic [7:0] e, logic s);
        res_t r;
        int   p;
        int   k;
        int   a;
        r = '0;
        if (m == 28'd0) begin
            r.zero = 1'b1;
        end else if (m[27]) begin
            r.sign = s;
            if (e == 8'd254) begin
                r.exp = 8'd255;
                r.ovf = 1'b1;
            end else begin
                r.mant = 27'(m >> 1) | 27'(m[0]);
                r.exp  = e + 8'd1;
            end
        end else begin
            p = 0;
            for (int i = 0; i < 27; i++) if (m[i]) p = i;
            k = 26 - p;
            r.sign = s;
            if (int'(e) > k) begin
                r.mant = 27'(m << k);
                r.exp  = 8'(int'(e) - k);
            end else begin
                a = (e == 8'd0) ? 0 : int'(e) - 1;
                r.mant   = 27'(m << a);
                r.denorm = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: score any output transfer, record any input transfer, then advance.
    task automatic tick(output bit in_fire, output bit out_fire);
        res_t e;
        #1;
        in_fire  = bus.i_valid && bus.o_ready && !rst;
        out_fire = bus.o_valid && bus.i_ready && !rst;
        if (out_fire) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("mant",  32'(bus.o_mant), 32'(e.mant));
                check("exp",   32'(bus.o_exp),  32'(e.exp));
                check("sign",  32'(bus.o_sign), 32'(e.sign));
                check("flags", 32'({bus.o_zero, bus.o_ovf, bus.o_denorm}),
                               32'({e.zero, e.ovf, e.denorm}));
            end
        end
        if (in_fire) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [27:0] m, logic [7:0] e, logic s, res_t expv);
        bit fi, fo;
        int n;
        bus.i_valid    = 1'b1;
        bus.i_sum_mant = m;
        bus.i_exp      = e;
        bus.i_sign     = s;
        pend           = expv;
        n  = 0;
        fi = 1'b0;
        while (!fi && n < 50) begin
            tick(fi, fo);
            n++;
        end
        if (!fi) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        bit fi, fo;
        int n;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick(fi, fo);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    task automatic check_idle(string tag);
        check({tag, "_valid"}, 32'(bus.o_valid), 32'(0));
        check({tag, "_ready"}, 32'(bus.o_ready), 32'(1));
        check({tag, "_mant"},  32'(bus.o_mant),  32'(0));
        check({tag, "_exp"},   32'(bus.o_exp),   32'(0));
        check({tag, "_flags"}, 32'({bus.o_sign, bus.o_zero, bus.o_ovf, bus.o_denorm}), 32'(0));
    endtask

    initial begin
        bit          fi, fo;
        int          idx;
        int          n;
        int          sent;
        int          k;
        logic [27:0] mask;
        logic [27:0] bp_mant [4];
        logic [7:0]  bp_exp  [4];
        logic [27:0] rm;
        logic [7:0]  re;
        logic        rs;

        checks = 0;
        errors = 0;
        pend   = '0;
        rst    = 1'b1;
        bus.i_valid    = 1'b0;
        bus.i_sum_mant = '0;
        bus.i_exp      = '0;
        bus.i_sign     = 1'b0;
        bus.i_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        // Directed cases, back to back with the consumer always ready.
        send(28'h8000000, 8'd127, 1'b0, mk(27'h4000000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0));
        send(28'h8000003, 8'd127, 1'b1, mk(27'h4000001, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0));
        send(28'h4000001, 8'd100, 1'b0, mk(27'h4000001, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0));
        send(28'h0000010, 8'd100, 1'b1, mk(27'h4000000, 8'd78,  1'b1, 1'b0, 1'b0, 1'b0));
        send(28'h0000010, 8'd10,  1'b0, mk(27'h0002000, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1));
        send(28'h0000000, 8'd50,  1'b1, mk(27'h0000000, 8'd0,   1'b0, 1'b1, 1'b0, 1'b0));
        send(28'h8000000, 8'd254, 1'b0, mk(27'h0000000, 8'd255, 1'b0, 1'b0, 1'b1, 1'b0));
        send(28'h4000001, 8'd0,   1'b1, mk(27'h4000001, 8'd0,   1'b1, 1'b0, 1'b0, 1'b1));
        send(28'h0000001, 8'd1,   1'b0, mk(27'h0000001, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1));
        drain();

        // Backpressure: four items offered while the consumer stalls for 3 cycles.
        bp_mant[0] = 28'h0000100; bp_exp[0] = 8'd90;
        bp_mant[1] = 28'h8000005; bp_exp[1] = 8'd3;
        bp_mant[2] = 28'h0123456; bp_exp[2] = 8'd200;
        bp_mant[3] = 28'h0000003; bp_exp[3] = 8'd12;
        bus.i_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            bus.i_valid    = 1'b1;
            bus.i_sum_mant = bp_mant[idx];
            bus.i_exp      = bp_exp[idx];
            bus.i_sign     = idx[0];
            pend           = model(bp_mant[idx], bp_exp[idx], idx[0]);
            tick(fi, fo);
            if (fi) idx++;
        end
        check("bp_accepted", 32'(idx), 32'(2));
        check("bp_ready_low", 32'(bus.o_ready), 32'(0));
        check("bp_valid_hold", 32'(bus.o_valid), 32'(1));
        bus.i_ready = 1'b1;
        n = 0;
        while (idx < 4 && n < 20) begin
            bus.i_valid    = 1'b1;
            bus.i_sum_mant = bp_mant[idx];
            bus.i_exp      = bp_exp[idx];
            bus.i_sign     = idx[0];
            pend           = model(bp_mant[idx], bp_exp[idx], idx[0]);
            tick(fi, fo);
            if (fi) idx++;
            n++;
        end
        check("bp_all_accepted", 32'(idx), 32'(4));
        drain();

        // Mid-stream reset: fill both stages, then reset and expect nothing to emerge.
        bus.i_ready = 1'b0;
        send(28'h8000000, 8'd127, 1'b1, mk(27'h4000000, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0));
        send(28'h4000001, 8'd100, 1'b1, mk(27'h4000001, 8'd100, 1'b1, 1'b0, 1'b0, 1'b0));
        bus.i_valid = 1'b0;
        rst = 1'b1;
        tick(fi, fo);
        check_idle("midrst");
        rst = 1'b0;
        sb.delete();
        bus.i_ready = 1'b1;
        repeat (3) begin
            tick(fi, fo);
            check("midrst_no_output", 32'(bus.o_valid), 32'(0));
        end
        send(28'h0000010, 8'd100, 1'b0, mk(27'h4000000, 8'd78, 1'b0, 1'b0, 1'b0, 1'b0));
        drain();

        // Random traffic with random consumer stalls, scored against the model.
        sent = 0;
        n    = 0;
        while (sent < 40 && n < 2000) begin
            n++;
            bus.i_ready = ($urandom_range(3) != 0);
            if (!bus.i_valid && $urandom_range(3) != 0) begin
                k    = $urandom_range(28);
                mask = 28'((64'(1) << k) - 64'(1));
                rm   = 28'($urandom) & mask;
                re   = 8'($urandom_range(254));
                rs   = 1'($urandom_range(1));
                bus.i_valid    = 1'b1;
                bus.i_sum_mant = rm;
                bus.i_exp      = re;
                bus.i_sign     = rs;
                pend           = model(rm, re, rs);
            end
            tick(fi, fo);
            if (fi) begin
                sent++;
                bus.i_valid = 1'b0;
            end
        end
        check("rand_sent", 32'(sent), 32'(40));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
